// File: rtl/conv1d_engine.sv
//==============================================================================
// Module      : conv1d_engine
// Description : 1-D convolution Z = X * Y over external X/Y read memories with
//               full/same/valid output shapes. Define CONV_SAT_EN for unsigned
//               saturation of dataZ; otherwise dataZ wraps (truncates).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv1d_engine #(
    parameter int DATAWIDTH_X      = 8,
    parameter int DATAWIDTH_Y      = 8,
    parameter int DATAWIDTH_Z      = 16,
    parameter int MEM_ADDR_XY_SIZE = 5,
    parameter int MEM_LAT          = 1
) (
    input  logic                        clk,
    input  logic                        clrh,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [MEM_ADDR_XY_SIZE:0]   sizeX,
    input  logic [MEM_ADDR_XY_SIZE:0]   sizeY,
    input  logic [DATAWIDTH_X-1:0]      dataX,
    input  logic [DATAWIDTH_Y-1:0]      dataY,
    output logic [MEM_ADDR_XY_SIZE-1:0] memX_addr,
    output logic [MEM_ADDR_XY_SIZE-1:0] memY_addr,
    output logic [MEM_ADDR_XY_SIZE:0]   memZ_addr,
    output logic [DATAWIDTH_Z-1:0]      dataZ,
    output logic                        writeZ,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int c_AW    = MEM_ADDR_XY_SIZE;
    localparam int c_ZAW   = MEM_ADDR_XY_SIZE + 1;
    localparam int c_KW    = MEM_ADDR_XY_SIZE + 2;
    localparam int c_PW    = DATAWIDTH_X + DATAWIDTH_Y;
    localparam int c_ACC_W = c_PW + MEM_ADDR_XY_SIZE + 1;
    localparam logic [c_KW-1:0] c_ONE = c_KW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [c_AW:0]        r_sx;
    logic [c_AW:0]        r_sy;
    logic [c_KW-1:0]      r_k;
    logic [c_KW-1:0]      r_kstart;
    logic [c_KW-1:0]      r_kend;
    logic [c_KW-1:0]      r_j;
    logic [c_KW-1:0]      r_jhi;
    logic [2:0]           r_drain;
    logic [MEM_LAT-1:0]   r_vld;
    logic [c_ACC_W-1:0]   r_acc;

    logic [c_KW-1:0]        w_sx;
    logic [c_KW-1:0]        w_sy;
    logic [c_KW-1:0]        w_kstart;
    logic [c_KW-1:0]        w_count;
    logic [c_KW-1:0]        w_kend;
    logic [c_KW-1:0]        w_knext;
    logic [c_KW-1:0]        w_jlo;
    logic [c_KW-1:0]        w_jhi;
    logic                   w_err;
    logic [c_PW-1:0]        w_prod;
    logic [c_ACC_W-1:0]     w_acc_next;
    logic [DATAWIDTH_Z-1:0] w_zval;

    // Output window and tap bounds; w_knext is the k about to enter RUN.
    always_comb begin
        w_sx     = c_KW'(r_sx);
        w_sy     = c_KW'(r_sy);
        w_kstart = '0;
        w_count  = '0;
        case (r_mode)
            2'b01: begin
                w_kstart = (w_sy - c_ONE) >> 1;
                w_count  = w_sx;
            end
            2'b10: begin
                w_kstart = w_sy - c_ONE;
                w_count  = w_sx - w_sy + c_ONE;
            end
            default: begin
                w_kstart = '0;
                w_count  = w_sx + w_sy - c_ONE;
            end
        endcase
        w_kend  = w_kstart + w_count - c_ONE;
        w_err   = (r_sx == '0) || (r_sy == '0) || (r_mode == 2'b11) ||
                  ((r_mode == 2'b10) && (r_sx < r_sy));
        w_knext = (r_state == S_SETUP) ? w_kstart : (r_k + c_ONE);
        w_jlo   = (w_knext >= w_sy) ? (w_knext - w_sy + c_ONE) : '0;
        w_jhi   = (w_knext < (w_sx - c_ONE)) ? w_knext : (w_sx - c_ONE);
    end

    // Product of the pair returned this cycle, valid when the delayed issue flag is set.
    always_comb begin
        w_prod     = c_PW'(dataX) * c_PW'(dataY);
        w_acc_next = r_acc + (r_vld[MEM_LAT-1] ? c_ACC_W'(w_prod) : '0);
`ifdef CONV_SAT_EN
        w_zval = ({{DATAWIDTH_Z{1'b0}}, w_acc_next} > {{c_ACC_W{1'b0}}, {DATAWIDTH_Z{1'b1}}})
                 ? '1 : DATAWIDTH_Z'(w_acc_next);
`else
        w_zval = DATAWIDTH_Z'(w_acc_next);
`endif
    end

    always_ff @(posedge clk) begin
        if (clrh) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_sx      <= '0;
            r_sy      <= '0;
            r_k       <= '0;
            r_kstart  <= '0;
            r_kend    <= '0;
            r_j       <= '0;
            r_jhi     <= '0;
            r_drain   <= '0;
            r_vld     <= '0;
            r_acc     <= '0;
            memX_addr <= '0;
            memY_addr <= '0;
            memZ_addr <= '0;
            dataZ     <= '0;
            writeZ    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            writeZ <= 1'b0;
            done   <= 1'b0;
            r_vld  <= MEM_LAT'({r_vld, (r_state == S_RUN)});
            r_acc  <= ((r_state == S_WRITE) || (r_state == S_SETUP)) ? '0 : w_acc_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_sx    <= sizeX;
                        r_sy    <= sizeY;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_err) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_kstart  <= w_kstart;
                        r_kend    <= w_kend;
                        r_k       <= w_knext;
                        r_j       <= w_jlo;
                        r_jhi     <= w_jhi;
                        memX_addr <= c_AW'(w_jlo);
                        memY_addr <= c_AW'(w_knext - w_jlo);
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_j == r_jhi) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_j       <= r_j + c_ONE;
                        memX_addr <= c_AW'(r_j + c_ONE);
                        memY_addr <= c_AW'(r_k - r_j - c_ONE);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 3'(MEM_LAT - 1)) begin
                        writeZ    <= 1'b1;
                        memZ_addr <= c_ZAW'(r_k - r_kstart);
                        dataZ     <= w_zval;
                        r_state   <= S_WRITE;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (r_k == r_kend) begin
                        err     <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_k       <= w_knext;
                        r_j       <= w_jlo;
                        r_jhi     <= w_jhi;
                        memX_addr <= c_AW'(w_jlo);
                        memY_addr <= c_AW'(w_knext - w_jlo);
                        r_state   <= S_RUN;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv1d_engine.sv
//==============================================================================
// Module      : tb_conv1d_engine
// Description : Self-checking bench for conv1d_engine (latency 1, latency 3 and
//               8-bit Z instances fed from shared X/Y memories).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv1d_engine;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clrh;
    logic          start;
    logic [1:0]    mode;
    logic [AW:0]   sizeX;
    logic [AW:0]   sizeY;

    logic [7:0]    mx [32];
    logic [7:0]    my [32];
    logic [7:0]    px [3][4];
    logic [7:0]    py [3][4];

    logic [AW-1:0] xa0, ya0, xa1, ya1, xa2, ya2;
    logic [AW:0]   za0, za1, za2;
    logic [15:0]   dz0, dz1;
    logic [7:0]    dz2;
    logic          wz0, wz1, wz2, bz0, bz1, bz2, dn0, dn1, dn2, er0, er1, er2;

    int checks   = 0;
    int failures = 0;

    int zd [3][64];
    int wc [3];
    int exp_z [3][64];
    int exp_n;
    int exp_done [3];
    int exp_err;
    int got_done [3];
    int got_err [3];
    int lat [3] = '{1, 3, 1};
    logic [AW-1:0] xa_before;

    typedef struct {
        int mode;
        int sx;
        int sy;
        int x [4];
        int y [4];
        int nz;
        int z [4];
        int done_cyc;
        int err;
    } vec_t;
    vec_t tbl [6];

`ifdef CONV_SAT_EN
    localparam int Z16_MID = 65535;
    localparam int Z8_FIRST = 255;
`else
    localparam int Z16_MID = 64514;
    localparam int Z8_FIRST = 1;
`endif

    always #5 clk = ~clk;

    conv1d_engine #(.DATAWIDTH_X(8), .DATAWIDTH_Y(8), .DATAWIDTH_Z(16),
                    .MEM_ADDR_XY_SIZE(AW), .MEM_LAT(1)) u_dut (
        .clk(clk), .clrh(clrh), .start(start), .mode(mode), .sizeX(sizeX), .sizeY(sizeY),
        .dataX(px[0][0]), .dataY(py[0][0]), .memX_addr(xa0), .memY_addr(ya0),
        .memZ_addr(za0), .dataZ(dz0), .writeZ(wz0), .busy(bz0), .done(dn0), .err(er0));

    conv1d_engine #(.DATAWIDTH_X(8), .DATAWIDTH_Y(8), .DATAWIDTH_Z(16),
                    .MEM_ADDR_XY_SIZE(AW), .MEM_LAT(3)) u_dut_l3 (
        .clk(clk), .clrh(clrh), .start(start), .mode(mode), .sizeX(sizeX), .sizeY(sizeY),
        .dataX(px[1][2]), .dataY(py[1][2]), .memX_addr(xa1), .memY_addr(ya1),
        .memZ_addr(za1), .dataZ(dz1), .writeZ(wz1), .busy(bz1), .done(dn1), .err(er1));

    conv1d_engine #(.DATAWIDTH_X(8), .DATAWIDTH_Y(8), .DATAWIDTH_Z(8),
                    .MEM_ADDR_XY_SIZE(AW), .MEM_LAT(1)) u_dut_w8 (
        .clk(clk), .clrh(clrh), .start(start), .mode(mode), .sizeX(sizeX), .sizeY(sizeY),
        .dataX(px[2][0]), .dataY(py[2][0]), .memX_addr(xa2), .memY_addr(ya2),
        .memZ_addr(za2), .dataZ(dz2), .writeZ(wz2), .busy(bz2), .done(dn2), .err(er2));

    // Synchronous read memories: stage s holds data read s+1 cycles ago.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int s = 3; s > 0; s--) begin
                px[i][s] <= px[i][s-1];
                py[i][s] <= py[i][s-1];
            end
        end
        px[0][0] <= mx[xa0];  py[0][0] <= my[ya0];
        px[1][0] <= mx[xa1];  py[1][0] <= my[ya1];
        px[2][0] <= mx[xa2];  py[2][0] <= my[ya2];
    end

    always @(negedge clk) begin
        if (wz0) begin zd[0][za0] = int'(dz0); wc[0]++; end
        if (wz1) begin zd[1][za1] = int'(dz1); wc[1]++; end
        if (wz2) begin zd[2][za2] = int'(dz2); wc[2]++; end
    end

    task automatic chk(input string nm, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    function automatic int fit(input longint v, input int w);
        longint top = (longint'(1) << w) - 1;
`ifdef CONV_SAT_EN
        return int'((v > top) ? top : v);
`else
        return int'(v & top);
`endif
    endfunction

    // Reference: full convolution by scattering every x[j]*y[i] into k=j+i.
    function automatic void model(input int m, input int sx, input int sy);
        longint full [64];
        int taps [64];
        int ks, cnt;
        exp_err = (sx == 0 || sy == 0 || m == 3 || (m == 2 && sx < sy)) ? 1 : 0;
        exp_n = 0;
        for (int i = 0; i < 3; i++) exp_done[i] = 2;
        if (exp_err == 1) return;
        for (int k = 0; k < 64; k++) begin full[k] = 0; taps[k] = 0; end
        for (int j = 0; j < sx; j++)
            for (int i = 0; i < sy; i++) begin
                full[j+i] += longint'(mx[j]) * longint'(my[i]);
                taps[j+i]++;
            end
        if (m == 0)      begin ks = 0;            cnt = sx + sy - 1; end
        else if (m == 1) begin ks = (sy - 1) / 2; cnt = sx;          end
        else             begin ks = sy - 1;       cnt = sx - sy + 1; end
        exp_n = cnt;
        for (int i = 0; i < 3; i++) begin
            exp_done[i] = 2;
            for (int q = 0; q < cnt; q++) exp_done[i] += taps[ks+q] + lat[i] + 1;
        end
        for (int q = 0; q < cnt; q++) begin
            exp_z[0][q] = fit(full[ks+q], 16);
            exp_z[1][q] = fit(full[ks+q], 16);
            exp_z[2][q] = fit(full[ks+q], 8);
        end
    endfunction

    task automatic clear_capture();
        for (int i = 0; i < 3; i++) begin
            wc[i] = 0;
            got_done[i] = -1;
            got_err[i] = -1;
            for (int q = 0; q < 64; q++) zd[i][q] = -1;
        end
    endtask

    task automatic run(input int m, input int sx, input int sy);
        clear_capture();
        xa_before = xa0;
        @(negedge clk);
        mode = 2'(m); sizeX = 6'(sx); sizeY = 6'(sy); start = 1'b1;
        @(posedge clk); #1;
        chk("setup_busy", bz0, 1);
        chk("setup_err_clear_i0", er0, 0);
        chk("setup_err_clear_i1", er1, 0);
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); sizeX = 6'($urandom); sizeY = 6'($urandom);
        for (int n = 1; n <= 6000; n++) begin
            @(posedge clk); #1;
            if (dn0 && got_done[0] < 0) begin got_done[0] = n + 1; got_err[0] = int'(er0); end
            if (dn1 && got_done[1] < 0) begin got_done[1] = n + 1; got_err[1] = int'(er1); end
            if (dn2 && got_done[2] < 0) begin got_done[2] = n + 1; got_err[2] = int'(er2); end
            if (got_done[0] >= 0 && got_done[1] >= 0 && got_done[2] >= 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_done", {bz0, bz1, bz2}, 0);
    endtask

    task automatic chk_inst(input int i, input string tag);
        chk($sformatf("%s_i%0d_done_cycle", tag, i), got_done[i], exp_done[i]);
        chk($sformatf("%s_i%0d_err", tag, i), got_err[i], exp_err);
        chk($sformatf("%s_i%0d_writes", tag, i), wc[i], exp_n);
        for (int q = 0; q < exp_n; q++)
            chk($sformatf("%s_i%0d_z%0d", tag, i, q), zd[i][q], exp_z[i][q]);
    endtask

    task automatic load_vec(input int t);
        for (int a = 0; a < 32; a++) begin mx[a] = 8'h00; my[a] = 8'h00; end
        for (int a = 0; a < 4; a++) begin mx[a] = 8'(tbl[t].x[a]); my[a] = 8'(tbl[t].y[a]); end
    endtask

    task automatic apply_vec(input int t);
        load_vec(t);
        model(tbl[t].mode, tbl[t].sx, tbl[t].sy);
        run(tbl[t].mode, tbl[t].sx, tbl[t].sy);
        chk($sformatf("t%0d_done_cycle", t), got_done[0], tbl[t].done_cyc);
        chk($sformatf("t%0d_err", t), got_err[0], tbl[t].err);
        chk($sformatf("t%0d_writes", t), wc[0], tbl[t].nz);
        for (int q = 0; q < tbl[t].nz; q++)
            chk($sformatf("t%0d_z%0d", t, q), zd[0][q], tbl[t].z[q]);
        chk_inst(1, $sformatf("t%0d", t));
        chk_inst(2, $sformatf("t%0d", t));
        if (tbl[t].err != 0) chk($sformatf("t%0d_no_read", t), xa0, xa_before);
        else chk($sformatf("t%0d_lat3_extra", t), got_done[1] - got_done[0], 2 * tbl[t].nz);
    endtask

    initial begin
        int d1, d2, sx, sy, m, late_done;

        tbl[0] = '{0, 3, 2, '{1, 2, 3, 0}, '{1, 1, 0, 0}, 4, '{1, 3, 5, 3}, 16, 0};
        tbl[1] = '{1, 4, 3, '{1, 2, 3, 4}, '{1, 1, 1, 0}, 4, '{3, 6, 9, 7}, 20, 0};
        tbl[2] = '{2, 4, 3, '{1, 2, 3, 4}, '{1, 1, 1, 0}, 2, '{6, 9, 0, 0}, 12, 0};
        tbl[3] = '{2, 2, 3, '{1, 2, 0, 0}, '{1, 1, 1, 0}, 0, '{0, 0, 0, 0}, 2, 1};
        tbl[4] = '{0, 3, 0, '{1, 2, 3, 0}, '{1, 1, 0, 0}, 0, '{0, 0, 0, 0}, 2, 1};
        tbl[5] = '{0, 2, 2, '{255, 255, 0, 0}, '{255, 255, 0, 0}, 3, '{65025, Z16_MID, 65025, 0}, 12, 0};

        for (int a = 0; a < 32; a++) begin mx[a] = 8'h00; my[a] = 8'h00; end
        clear_capture();
        clrh = 1'b1; start = 1'b0; mode = 2'b00; sizeX = '0; sizeY = '0;
        repeat (3) @(posedge clk);
        // start coincident with reset must be ignored
        @(negedge clk); start = 1'b1; mode = 2'b00; sizeX = 6'd3; sizeY = 6'd2;
        @(posedge clk); #1;
        chk("rst_zero_i0", {xa0, ya0, za0, dz0, wz0, bz0, dn0, er0}, 0);
        chk("rst_zero_i1", {xa1, ya1, za1, dz1, wz1, bz1, dn1, er1}, 0);
        chk("rst_zero_i2", {xa2, ya2, za2, dz2, wz2, bz2, dn2, er2}, 0);
        @(negedge clk); clrh = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_beats_start", bz0, 0);

        for (int t = 0; t < 6; t++) apply_vec(t);
        chk("sat_w8_first", zd[2][0], Z8_FIRST);

        // Reset while the second sample of the first vector is in RUN.
        load_vec(0);
        clear_capture();
        @(negedge clk);
        mode = 2'b00; sizeX = 6'd3; sizeY = 6'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); clrh = 1'b1;
        @(posedge clk); #1;
        chk("midrst_zero_i0", {xa0, ya0, za0, dz0, wz0, bz0, dn0, er0}, 0);
        chk("midrst_zero_i1", {xa1, ya1, za1, dz1, wz1, bz1, dn1, er1}, 0);
        chk("midrst_zero_i2", {xa2, ya2, za2, dz2, wz2, bz2, dn2, er2}, 0);
        chk("midrst_writes_before", wc[0], 1);
        @(negedge clk); clrh = 1'b0;
        late_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (dn0 || dn1 || dn2 || bz0) late_done = 1;
        end
        chk("midrst_no_activity", late_done, 0);
        chk("midrst_no_more_writes", wc[0], 1);
        apply_vec(0);

        // Back-to-back: start held high is accepted in the IDLE cycle after DONE.
        load_vec(0);
        clear_capture();
        d1 = -1; d2 = -1;
        @(negedge clk);
        mode = 2'b00; sizeX = 6'd3; sizeY = 6'd2; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (dn0) begin
                if (d1 < 0) d1 = n + 1;
                else d2 = n + 1;
            end
            if (d2 >= 0) break;
        end
        @(negedge clk); start = 1'b0;
        repeat (200) @(posedge clk);
        chk("b2b_first_done", d1, 16);
        chk("b2b_second_done", d2, 33);
        chk("b2b_writes", wc[0], 8);

        // Randomized shapes, sizes and sample values against the model.
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a < 32; a++) begin
                mx[a] = 8'($urandom);
                my[a] = 8'($urandom);
            end
            m  = int'($urandom_range(0, 3));
            sx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 32 : 8));
            sy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 32 : 8));
            model(m, sx, sy);
            run(m, sx, sy);
            for (int i = 0; i < 3; i++) chk_inst(i, $sformatf("rnd%0d", r));
            if (exp_err != 0) chk($sformatf("rnd%0d_no_read", r), xa0, xa_before);
        end

        // Largest sequences with full-scale samples.
        for (int a = 0; a < 32; a++) begin mx[a] = 8'hFF; my[a] = 8'hFF; end
        model(0, 32, 32);
        run(0, 32, 32);
        for (int i = 0; i < 3; i++) chk_inst(i, "max");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv1d_engine.md
# conv1d_engine

- Parametrised 1-D discrete convolution engine. It computes Z = X ∗ Y from two external synchronous read memories and writes each Z sample to an output memory.
- Next-generation convolution datapath: width, depth and memory read latency are generic; full/same/valid output shapes are supported; size errors are detected; saturation is optional.
- Sits between the X/Y sample RAMs and the Z result RAM, under the same start/busy/done control as the rest of the convolution subsystem.

## Interface
- DATAWIDTH_X, 8, unsigned X sample width
- DATAWIDTH_Y, 8, unsigned Y sample width
- DATAWIDTH_Z, 16, written Z sample width
- MEM_ADDR_XY_SIZE, 5, X/Y address width; max sequence length 2^MEM_ADDR_XY_SIZE
- MEM_LAT, 1, X/Y memory read latency in cycles (1..4)
- clk  input  1  clock, all logic rising-edge
- clrh  input  1  reset, synchronous, active-high
- start  input  1  start pulse; sampled only in IDLE
- mode  input  2  00 full, 01 same, 10 valid, 11 reserved (error)
- sizeX  input  MEM_ADDR_XY_SIZE+1  length of X (1..2^MEM_ADDR_XY_SIZE)
- sizeY  input  MEM_ADDR_XY_SIZE+1  length of Y
- dataX  input  DATAWIDTH_X  X read data, valid MEM_LAT cycles after memX_addr
- dataY  input  DATAWIDTH_Y  Y read data, same latency
- memX_addr  output  MEM_ADDR_XY_SIZE  X read address
- memY_addr  output  MEM_ADDR_XY_SIZE  Y read address
- memZ_addr  output  MEM_ADDR_XY_SIZE+1  Z write address
- dataZ  output  DATAWIDTH_Z  Z write data
- writeZ  output  1  Z write strobe, one cycle per sample
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- err  output  1  last accepted request was invalid; held until next accepted start

## Operation
- **Start:** `start`=1 in IDLE latches mode, sizeX and sizeY. Later changes to these inputs are ignored. `start` outside IDLE is ignored.
- **Convolution:** z[k] = Σ x[j]·y[k−j], with j from max(0, k−sizeY+1) to min(k, sizeX−1).
- **Output range in full-convolution index k, with Z address = k − kstart:**
  - full: kstart = 0, count = sizeX+sizeY−1.
  - same: kstart = floor((sizeY−1)/2), count = sizeX.
  - valid: kstart = sizeY−1, count = sizeX−sizeY+1.
- **Errors:** any of sizeX=0, sizeY=0, mode=11, or valid mode with sizeX<sizeY sets `err`. The engine goes SETUP→DONE with no reads and no writes.
- **FSM states:** IDLE, SETUP, RUN, DRAIN, WRITE, DONE.
  - IDLE: start → SETUP.
  - SETUP (1 cycle): compute kstart/kend and the j bounds for the first k; go to DONE on error, else RUN.
  - RUN: issue one (memX_addr=j, memY_addr=k−j) pair per cycle, j ascending. After the last j of this k, go to DRAIN.
  - DRAIN: MEM_LAT cycles. The accumulator adds returned products on a MEM_LAT-deep valid pipeline.
  - WRITE (1 cycle): writeZ=1, memZ_addr=k−kstart, dataZ=result. The accumulator is cleared for the next k. Go to RUN with k+1, or to DONE if k=kend.
  - DONE (1 cycle): done=1, then IDLE.
- **Arithmetic:**
  - Products are DATAWIDTH_X+DATAWIDTH_Y bits, unsigned.
  - The accumulator is DATAWIDTH_X+DATAWIDTH_Y+MEM_ADDR_XY_SIZE+1 bits and never overflows internally.
  - dataZ is formed from the accumulator as described under Configuration.
- Address outputs hold their last value outside RUN.

## Timing
- **Reset value of every output is 0.** Reset wins over start in the same cycle.
- Reset mid-operation aborts immediately: no further writeZ, no done pulse, state IDLE next cycle.
- busy=1 in SETUP, RUN, DRAIN, WRITE and DONE; busy=0 in IDLE.
- err updates on entry to DONE. It is cleared when the next start is accepted.
- If start is the cycle-0 edge, SETUP is cycle 1. Each output sample costs taps(k)+MEM_LAT+1 cycles. done rises in cycle 1 + Σ(taps(k)+MEM_LAT+1) + 1.
- A read issued in RUN cycle c has its data sampled at cycle c+MEM_LAT. dataZ/memZ_addr are valid only while writeZ=1.
- Back-to-back: start is accepted in the IDLE cycle immediately following DONE.

## Configuration
- `CONV_SAT_EN` defined: dataZ = min(acc, 2^DATAWIDTH_Z−1), i.e. unsigned saturation.
- `CONV_SAT_EN` undefined: dataZ = acc[DATAWIDTH_Z−1:0], i.e. wrap-around truncation.

## Test plan
- Full, X={1,2,3}, Y={1,1}, MEM_LAT=1 -> writes Z[0..3]={1,3,5,3}; done at cycle 16; err=0.
- Same, X={1,2,3,4}, Y={1,1,1} -> Z[0..3]={3,6,9,7}, exactly 4 writeZ pulses.
- Valid, same X/Y; repeat with MEM_LAT=3 -> Z[0..1]={6,9} in both cases; the MEM_LAT=3 run has 2 extra cycles per sample.
- Valid with sizeX=2, sizeY=3; then sizeY=0 in full mode -> done 2 cycles after start, err=1, no writeZ or reads; err clears on the next valid start.
- DATAWIDTH_Z=8, X={255,255}, Y={255,255}, full -> first sample written as 255 with `CONV_SAT_EN` defined, 1 without.
- clrh pulsed during RUN of the second sample of the first test, then a fresh start -> no write after reset; all outputs 0 the next cycle; the rerun produces {1,3,5,3}.
